// File: rtl/cpu_result_collector_pkg.sv
// Shared CPU constants: default data-path widths and result buffer depth.
// Helper for sizing occupancy counters that must represent 0..DEPTH inclusive.
package cpu_result_collector_pkg;

  localparam int CPU_DATA_W    = 8;
  localparam int CPU_TS_W      = 8;
  localparam int CPU_RES_DEPTH = 8;

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_result_collector_sync_fifo.sv
// Purpose: first-word fall-through synchronous FIFO with full/empty/count.
// Latency: a push is visible at rdata one cycle later. Backpressure: a push
// while full is ignored unless a pop happens in the same cycle.
module sync_fifo
  import cpu_result_collector_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = CPU_RES_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [occ_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Zero when empty so nothing stale leaks out after reset or a flush.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_result_collector.sv
// Purpose: timestamps CPU results on the rising edge of done_in and queues them.
// Latency: 1 cycle capture to out_valid. Backpressure: out_ready holds the head;
// captures arriving while full are dropped and latch the sticky overflow flag.
module cpu_result_collector
  import cpu_result_collector_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int TS_W   = CPU_TS_W,
  parameter int DEPTH  = CPU_RES_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_in,
  input  logic [DATA_W-1:0]       result_in,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [TS_W-1:0]         out_ts,
  output logic [occ_w(DEPTH)-1:0] count,
  output logic                    overflow
);

  logic            done_q;
  logic            cap;
  logic [TS_W-1:0] ts;
  logic            full;
  logic            empty;

  assign cap       = done_in & ~done_q;
  assign out_valid = ~empty;

  // Edge detector keeps tracking through clear so a held done_in cannot re-fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ts <= '0;
    else if (clear) ts <= '0;
    else            ts <= ts + TS_W'(1);
  end

  // Full implies non-empty, so out_ready alone guarantees a same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            overflow <= 1'b0;
    else if (clear)                     overflow <= 1'b0;
    else if (cap && full && !out_ready) overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (DATA_W + TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .push  (cap & ~clear),
    .wdata ({result_in, ts}),
    .pop   (out_ready & ~clear),
    .rdata ({out_data, out_ts}),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_cpu_result_collector.sv
// Directed scenarios plus randomized traffic, checked against a queue-based model.
module tb_cpu_result_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done_in = 1'b0;
  logic [7:0] result_in = 8'h00;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ts;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  cpu_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_in),
    .result_in (result_in),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Behavioural model: a queue of {result, timestamp} plus sticky flag and counter.
  logic [15:0] mq[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_ts  = 8'd0;
  logic        m_dq  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ts  = 8'd0;
      m_dq  = 1'b0;
    end else begin
      bit cap;
      bit popping;
      bit accept;
      cap  = done_in && !m_dq;
      m_dq = done_in;
      if (clear) begin
        mq.delete();
        m_ovf = 1'b0;
        m_ts  = 8'd0;
      end else begin
        popping = (mq.size() > 0) && out_ready;
        accept  = cap && ((mq.size() < 8) || popping);
        if (cap && !accept) m_ovf = 1'b1;
        if (popping) void'(mq.pop_front());
        if (accept) mq.push_back({result_in, m_ts});
        m_ts = m_ts + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("model_count", 32'(count), 32'(mq.size()));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      check("model_data", 32'(out_data), 32'(mq[0][15:8]));
      check("model_ts", 32'(out_ts), 32'(mq[0][7:0]));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    done_in = 1'b1;
    result_in = d;
    step();
    done_in = 1'b0;
    step();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int pr;
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ts", 32'(out_ts), 0);
    rst = 1'b0;

    // Capture at timestamp 5: first edge after reset is timestamp 0.
    repeat (5) step();
    done_in = 1'b1;
    result_in = 8'h2A;
    step();
    done_in = 1'b0;
    check("ts5_valid", 32'(out_valid), 1);
    check("ts5_data", 32'(out_data), 32'h2A);
    check("ts5_ts", 32'(out_ts), 5);
    check("ts5_count", 32'(count), 1);
    pop_one();

    // done_in held for 4 cycles produces a single entry.
    done_in = 1'b1;
    result_in = 8'h11;
    repeat (4) step();
    done_in = 1'b0;
    step();
    check("hold_count", 32'(count), 1);
    check("hold_data", 32'(out_data), 32'h11);
    pop_one();

    // Nine captures into an eight-deep buffer.
    for (int i = 1; i <= 9; i++) pulse(8'(i));
    check("ovf_count", 32'(count), 8);
    check("ovf_flag", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(out_data), 32'(i));
      pop_one();
    end
    check("drain_empty", 32'(out_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Clear with three stored entries and a concurrent capture.
    for (int i = 0; i < 3; i++) pulse(8'h31 + 8'(i));
    check("pre_clear_count", 32'(count), 3);
    clear = 1'b1;
    done_in = 1'b1;
    result_in = 8'h77;
    step();
    clear = 1'b0;
    check("clr_count", 32'(count), 0);
    check("clr_valid", 32'(out_valid), 0);
    check("clr_overflow", 32'(overflow), 0);
    step();
    check("clr_no_recapture", 32'(count), 0);
    done_in = 1'b0;
    step();
    done_in = 1'b1;
    result_in = 8'h55;
    step();
    done_in = 1'b0;
    check("clr_ts_restart", 32'(out_ts), 2);
    check("clr_next_data", 32'(out_data), 32'h55);
    pop_one();

    // Full with a same-cycle pop and capture.
    for (int i = 0; i < 8; i++) pulse(8'h20 + 8'(i));
    done_in = 1'b1;
    result_in = 8'hFF;
    out_ready = 1'b1;
    step();
    done_in = 1'b0;
    out_ready = 1'b0;
    check("full_swap_count", 32'(count), 8);
    check("full_swap_ovf", 32'(overflow), 0);
    check("full_swap_head", 32'(out_data), 32'h21);
    for (int i = 0; i < 7; i++) pop_one();
    check("full_swap_tail", 32'(out_data), 32'hFF);
    pop_one();

    // Timestamp wrap: captures at 254 and at 1.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (254) step();
    done_in = 1'b1;
    result_in = 8'hA0;
    step();
    done_in = 1'b0;
    step();
    step();
    done_in = 1'b1;
    result_in = 8'hA1;
    step();
    done_in = 1'b0;
    check("wrap_ts_a", 32'(out_ts), 254);
    pop_one();
    check("wrap_ts_b", 32'(out_ts), 1);
    pop_one();

    // Randomized traffic with varying drain pressure, clears and async resets.
    for (int i = 0; i < 4000; i++) begin
      pr = (i / 500) % 4;
      done_in   = 1'($urandom_range(0, 1));
      result_in = 8'($urandom);
      out_ready = ($urandom_range(0, 3) < pr) ? 1'b1 : 1'b0;
      clear     = ($urandom_range(0, 80) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 600) == 0) begin
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    done_in = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
